// File: rtl/shift_register_univ_n.sv
// Universal N-bit shift register with a counted auto-shift engine.
// Idle edges apply the operation selected by s. A start request with a shift
// mode latches that mode and performs exactly `count` shifts on consecutive
// edges. busy flags the remaining steps, and done pulses once at the end.
module shift_register_univ_n #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1) + 1
) (
  input  logic             CLK,
  input  logic             Clear,
  input  logic [2:0]       s,
  input  logic [WIDTH-1:0] I_par,
  input  logic             MSB_in,
  input  logic             LSB_in,
  input  logic             start,
  input  logic [CW-1:0]    count,
  output logic [WIDTH-1:0] A_par,
  output logic             SO_right,
  output logic             SO_left,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // Next register value for a given operation; serial inputs are always live.
  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] par,
    input logic             msb,
    input logic             lsb
  );
    logic [WIDTH-1:0] res;
    case (op)
      MODE_HOLD: res = a;
      MODE_SHR:  res = {msb, a[WIDTH-1:1]};
      MODE_SHL:  res = {a[WIDTH-2:0], lsb};
      MODE_LOAD: res = par;
      MODE_ROR:  res = {a[0], a[WIDTH-1:1]};
      MODE_ROL:  res = {a[WIDTH-2:0], a[WIDTH-1]};
      MODE_ASR:  res = {a[WIDTH-1], a[WIDTH-1:1]};
      MODE_CLR:  res = '0;
      default:   res = a;
    endcase
    return res;
  endfunction

  // Only these modes may be run by the auto-shift engine.
  function automatic logic is_shift(input logic [2:0] op);
    logic res;
    case (op)
      MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_ASR: res = 1'b1;
      default:                                          res = 1'b0;
    endcase
    return res;
  endfunction

  logic [CW-1:0] remain;     // shifts still to perform after the current edge
  logic [2:0]    mode_lat;   // shift mode captured when the request was accepted
  logic [CW-1:0] remain_dec;
  logic [CW-1:0] count_dec;

  assign remain_dec = remain - CNT_ONE;
  assign count_dec  = count - CNT_ONE;

  // Serial outputs are plain taps of the register.
  assign SO_right = A_par[0];
  assign SO_left  = A_par[WIDTH-1];

  // Register, step counter and status flags; Clear overrides everything.
  always_ff @(posedge CLK) begin
    if (Clear) begin
      A_par    <= '0;
      remain   <= '0;
      mode_lat <= MODE_HOLD;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (remain != '0) begin
      // Auto-shift in flight: s, I_par, start and count are ignored.
      A_par  <= apply_op(mode_lat, A_par, I_par, MSB_in, LSB_in);
      remain <= remain_dec;
      busy   <= (remain_dec != '0);
      done   <= (remain == CNT_ONE);
    end else if (start && is_shift(s)) begin
      mode_lat <= s;
      if (count == '0) begin
        // Zero-length request completes immediately without touching A_par.
        done <= 1'b1;
        busy <= 1'b0;
      end else begin
        // The accepting edge already performs the first shift.
        A_par  <= apply_op(s, A_par, I_par, MSB_in, LSB_in);
        remain <= count_dec;
        busy   <= (count_dec != '0);
        done   <= (count == CNT_ONE);
      end
    end else begin
      A_par <= apply_op(s, A_par, I_par, MSB_in, LSB_in);
      busy  <= 1'b0;
      done  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_register_univ_n.sv
// Scoreboard bench for shift_register_univ_n (WIDTH=8). The driver pushes the
// hand-computed state expected after each edge, and a monitor pops and compares it.
module tb_shift_register_univ_n;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1) + 1;

  logic             clk;
  logic             clear;
  logic [2:0]       s;
  logic [WIDTH-1:0] i_par;
  logic             msb_in;
  logic             lsb_in;
  logic             start;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_par;
  logic             so_right;
  logic             so_left;
  logic             busy;
  logic             done;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic             busy;
    logic             done;
    string            nm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  shift_register_univ_n #(.WIDTH(WIDTH), .CW(CW)) dut (
    .CLK      (clk),
    .Clear    (clear),
    .s        (s),
    .I_par    (i_par),
    .MSB_in   (msb_in),
    .LSB_in   (lsb_in),
    .start    (start),
    .count    (count),
    .A_par    (a_par),
    .SO_right (so_right),
    .SO_left  (so_left),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  // One clock edge: drive inputs, queue the expected post-edge state.
  task automatic step(input logic clr, input logic [2:0] sm, input logic [WIDTH-1:0] ip,
                      input logic msb, input logic lsb, input logic st, input logic [CW-1:0] cnt,
                      input logic [WIDTH-1:0] ea, input logic eb, input logic ed, input string nm);
    exp_t e;
    @(negedge clk);
    clear  = clr;
    s      = sm;
    i_par  = ip;
    msb_in = msb;
    lsb_in = lsb;
    start  = st;
    count  = cnt;
    e.a    = ea;
    e.busy = eb;
    e.done = ed;
    e.nm   = nm;
    sb.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: after every edge, compare DUT state against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.nm, ".A_par"}, a_par, e.a);
        chk({e.nm, ".busy"}, {7'd0, busy}, {7'd0, e.busy});
        chk({e.nm, ".done"}, {7'd0, done}, {7'd0, e.done});
        chk({e.nm, ".SO_right"}, {7'd0, so_right}, {7'd0, e.a[0]});
        chk({e.nm, ".SO_left"}, {7'd0, so_left}, {7'd0, e.a[WIDTH-1]});
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] exp_a;
    clear = 1'b1; s = 3'b000; i_par = 8'h00; msb_in = 1'b0; lsb_in = 1'b0;
    start = 1'b0; count = '0;

    // Reset state
    step(1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, "reset");

    // Clear has priority over a parallel load
    step(1'b0, 3'b011, 8'hA5, 1'b0, 1'b0, 1'b0, 5'd0, 8'hA5, 1'b0, 1'b0, "load_a5");
    step(1'b1, 3'b011, 8'hFF, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, "clear_prio");

    // Arithmetic shift right, then rotate right
    step(1'b0, 3'b011, 8'h96, 1'b0, 1'b0, 1'b0, 5'd0, 8'h96, 1'b0, 1'b0, "load_96");
    step(1'b0, 3'b110, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 8'hCB, 1'b0, 1'b0, "asr");
    step(1'b0, 3'b100, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 8'hE5, 1'b0, 1'b0, "ror");

    // Auto rotate-left by 3; disruptive inputs during the run must be ignored
    step(1'b0, 3'b011, 8'h81, 1'b0, 1'b0, 1'b0, 5'd0, 8'h81, 1'b0, 1'b0, "load_81");
    step(1'b0, 3'b101, 8'h00, 1'b0, 1'b0, 1'b1, 5'd3, 8'h03, 1'b1, 1'b0, "arol_e1");
    step(1'b0, 3'b011, 8'h00, 1'b0, 1'b0, 1'b1, 5'd7, 8'h06, 1'b1, 1'b0, "arol_e2");
    step(1'b0, 3'b111, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 8'h0C, 1'b0, 1'b1, "arol_e3");
    step(1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 8'h0C, 1'b0, 1'b0, "arol_after");

    // Plain serial shifts and hold
    step(1'b0, 3'b001, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 8'h86, 1'b0, 1'b0, "shr_msb1");
    step(1'b0, 3'b010, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 8'h0D, 1'b0, 1'b0, "shl_lsb1");
    step(1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 8'h0D, 1'b0, 1'b0, "hold");

    // Auto shift-right with count 10, past the register width
    step(1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, "clr_before_10");
    for (int k = 1; k <= 10; k++) begin
      exp_a = (k >= 8) ? 8'hFF : ~(8'hFF >> k);
      step(1'b0, (k == 1) ? 3'b001 : 3'b011, 8'h00, 1'b1, 1'b0, (k == 1), 5'd10,
           exp_a, (k < 10), (k == 10), $sformatf("ashr10_e%0d", k));
    end

    // Back-to-back: new start accepted in the done cycle, n=1 never shows busy
    step(1'b0, 3'b110, 8'h00, 1'b0, 1'b0, 1'b1, 5'd1, 8'hFF, 1'b0, 1'b1, "b2b_asr_n1");
    step(1'b0, 3'b010, 8'h00, 1'b0, 1'b0, 1'b1, 5'd2, 8'hFE, 1'b1, 1'b0, "b2b_shl_e1");
    step(1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 8'hFC, 1'b0, 1'b1, "b2b_shl_e2");
    step(1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 8'hFC, 1'b0, 1'b0, "b2b_after");

    // Abort with Clear on the 3rd edge; no done pulse may follow
    step(1'b0, 3'b011, 8'h01, 1'b0, 1'b0, 1'b0, 5'd0, 8'h01, 1'b0, 1'b0, "load_01");
    step(1'b0, 3'b010, 8'h00, 1'b0, 1'b0, 1'b1, 5'd5, 8'h02, 1'b1, 1'b0, "abort_e1");
    step(1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 8'h04, 1'b1, 1'b0, "abort_e2");
    step(1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, "abort_clr");
    for (int k = 0; k < 4; k++)
      step(1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0,
           $sformatf("abort_quiet%0d", k));

    // Ignored start on a non-shift mode, then zero-count start
    step(1'b0, 3'b011, 8'h3C, 1'b0, 1'b0, 1'b1, 5'd4, 8'h3C, 1'b0, 1'b0, "start_load");
    step(1'b0, 3'b001, 8'h00, 1'b1, 1'b0, 1'b1, 5'd0, 8'h3C, 1'b0, 1'b1, "start_n0");
    step(1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 8'h3C, 1'b0, 1'b0, "n0_after");

    // Drain the scoreboard; anything left means the monitor missed an edge
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 8'(sb.size()), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
